// File: rtl/cpu_types_pkg.sv
// Shared types for the pipelined core front end.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Fetch FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DROP   = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

  // IF/ID pipeline latch contents.
  typedef struct packed {
    logic  valid;
    word_t instr;
    word_t pc;
    word_t npc;
  } ifid_t;

  localparam int unsigned DEFAULT_PC_STEP = 4;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: PC feedback, instruction memory port, control inputs and IF/ID outputs.
interface fetch_stage_if;
  import cpu_types_pkg::*;

  word_t pc_cur;
  word_t pc_next;
  logic  pc_EN;
  logic  imemREN;
  word_t imemaddr;
  logic  ihit;
  word_t imemload;
  logic  stall;
  logic  redirect;
  word_t redirect_pc;
  logic  halt;
  logic  ifid_valid;
  word_t ifid_instr;
  word_t ifid_pc;
  word_t ifid_npc;

  // Fetch stage side.
  modport master (
    input  pc_cur, ihit, imemload, stall, redirect, redirect_pc, halt,
    output pc_next, pc_EN, imemREN, imemaddr, ifid_valid, ifid_instr, ifid_pc, ifid_npc
  );

  // Surrounding core / memory side.
  modport slave (
    output pc_cur, ihit, imemload, stall, redirect, redirect_pc, halt,
    input  pc_next, pc_EN, imemREN, imemaddr, ifid_valid, ifid_instr, ifid_pc, ifid_npc
  );

endinterface

// File: rtl/ifid_latch.sv
// IF/ID pipeline register. Flush wins over load and only kills the valid bit.
module ifid_latch
  import cpu_types_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  load_i,
  input  logic  flush_i,
  input  ifid_t data_i,
  output ifid_t data_o
);

  ifid_t ifid_q;

  // Register update: async clear, flush before load, otherwise hold.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ifid_q <= '0;
    end else if (flush_i) begin
      ifid_q.valid <= 1'b0;
    end else if (load_i) begin
      ifid_q <= data_i;
    end
  end

  assign data_o = ifid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: fetch FSM, next-PC mux and IF/ID latch control.
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter int unsigned PC_STEP = DEFAULT_PC_STEP
) (
  input logic          CLK,
  input logic          RST,
  fetch_stage_if.master bus
);

  fetch_state_t state_q, state_d;
  word_t        drop_addr_q, drop_addr_d;
  word_t        pc_plus;
  logic         ifid_load, ifid_flush;
  ifid_t        ifid_d, ifid_q;

  // Wraps modulo 2^32 by construction.
  assign pc_plus = bus.pc_cur + word_t'(PC_STEP);

  assign ifid_d = '{valid: 1'b1, instr: bus.imemload, pc: bus.pc_cur, npc: pc_plus};

  // Next state, memory request, next-PC mux and IF/ID control.
  always_comb begin
    state_d      = state_q;
    drop_addr_d  = drop_addr_q;
    bus.pc_EN    = 1'b0;
    bus.pc_next  = pc_plus;
    bus.imemREN  = 1'b0;
    bus.imemaddr = bus.pc_cur;
    ifid_load    = 1'b0;
    ifid_flush   = 1'b0;

    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        bus.imemREN = 1'b1;
        if (bus.redirect) begin
          bus.pc_EN   = 1'b1;
          bus.pc_next = bus.redirect_pc;
          ifid_flush  = 1'b1;
          // Request still in flight: remember it so we can drain the stale response.
          if (!bus.ihit) begin
            drop_addr_d = bus.pc_cur;
            state_d     = DROP;
          end
        end else if (bus.halt) begin
          state_d    = HALTED;
          ifid_flush = !bus.stall;
        end else if (bus.stall) begin
          // Hold everything; the same address is refetched after the stall.
        end else if (bus.ihit) begin
          ifid_load = 1'b1;
          bus.pc_EN = 1'b1;
        end else begin
          ifid_flush = 1'b1;
        end
      end
      DROP: begin
        // Keep the original request stable until memory answers.
        bus.imemREN  = 1'b1;
        bus.imemaddr = drop_addr_q;
        if (bus.ihit) begin
          state_d = FETCH;
        end
        if (bus.redirect) begin
          bus.pc_EN   = 1'b1;
          bus.pc_next = bus.redirect_pc;
        end
        ifid_flush = !bus.stall;
      end
      HALTED: begin
        ifid_flush = !bus.stall;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and drop address registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      drop_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      drop_addr_q <= drop_addr_d;
    end
  end

  ifid_latch u_ifid_latch (
    .clk_i   (CLK),
    .rst_i   (RST),
    .load_i  (ifid_load),
    .flush_i (ifid_flush),
    .data_i  (ifid_d),
    .data_o  (ifid_q)
  );

  assign bus.ifid_valid = ifid_q.valid;
  assign bus.ifid_instr = ifid_q.instr;
  assign bus.ifid_pc    = ifid_q.pc;
  assign bus.ifid_npc   = ifid_q.npc;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a PC register and simple instruction memory model.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        set_pc;
  logic [31:0] set_val;
  logic [31:0] pc_q;
  int          n_checks;
  int          n_errors;

  fetch_stage_if bus ();

  fetch_stage #(
    .PC_STEP (4)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // PC register; set_pc lets the bench jump to a chosen address.
  always @(posedge clk or posedge rst) begin
    if (rst) pc_q <= 32'h0;
    else if (set_pc) pc_q <= set_val;
    else if (bus.pc_EN) pc_q <= bus.pc_next;
  end

  assign bus.pc_cur   = pc_q;
  // Memory returns an address-tagged word.
  assign bus.imemload = bus.imemaddr ^ 32'hA5A5_0000;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    rst             = 1'b1;
    set_pc          = 1'b0;
    set_val         = 32'h0;
    bus.ihit        = 1'b0;
    bus.stall       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.halt        = 1'b0;

    // Reset state.
    tick();
    tick();
    check_eq("rst_ren", 32'(bus.imemREN), 32'd0);
    check_eq("rst_pcen", 32'(bus.pc_EN), 32'd0);
    check_eq("rst_valid", 32'(bus.ifid_valid), 32'd0);
    check_eq("rst_ifid_pc", bus.ifid_pc, 32'h0);
    check_eq("rst_ifid_instr", bus.ifid_instr, 32'h0);

    // 1. Reset release and streaming.
    bus.ihit = 1'b1;
    rst      = 1'b0;
    #1;
    check_eq("first_cycle_ren", 32'(bus.imemREN), 32'd0);
    tick();
    check_eq("second_cycle_ren", 32'(bus.imemREN), 32'd1);
    check_eq("second_cycle_addr", bus.imemaddr, 32'h0);
    check_eq("second_cycle_pcen", 32'(bus.pc_EN), 32'd1);
    check_eq("second_cycle_pcnext", bus.pc_next, 32'h4);
    tick();
    check_eq("s0_valid", 32'(bus.ifid_valid), 32'd1);
    check_eq("s0_pc", bus.ifid_pc, 32'h0);
    check_eq("s0_npc", bus.ifid_npc, 32'h4);
    check_eq("s0_instr", bus.ifid_instr, 32'hA5A5_0000);
    tick();
    check_eq("s1_pc", bus.ifid_pc, 32'h4);
    check_eq("s1_npc", bus.ifid_npc, 32'h8);
    tick();
    check_eq("s2_pc", bus.ifid_pc, 32'h8);
    check_eq("s2_npc", bus.ifid_npc, 32'hC);
    check_eq("s2_instr", bus.ifid_instr, 32'hA5A5_0008);
    tick();
    check_eq("s3_pc", bus.ifid_pc, 32'hC);

    // 2. Stall at 0x10 with data available.
    bus.stall = 1'b1;
    #1;
    check_eq("stall_addr", bus.imemaddr, 32'h10);
    check_eq("stall_pcen", 32'(bus.pc_EN), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall_hold_pc", bus.ifid_pc, 32'hC);
      check_eq("stall_hold_valid", 32'(bus.ifid_valid), 32'd1);
    end
    bus.stall = 1'b0;
    #1;
    check_eq("unstall_pcen", 32'(bus.pc_EN), 32'd1);
    check_eq("unstall_pcnext", bus.pc_next, 32'h14);
    tick();
    check_eq("unstall_pc10", bus.ifid_pc, 32'h10);
    tick();
    check_eq("unstall_pc14", bus.ifid_pc, 32'h14);
    tick();
    tick();
    check_eq("pre_redir_pc", bus.ifid_pc, 32'h1C);

    // 3. Redirect with hit at 0x20.
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h200;
    #1;
    check_eq("redir_hit_addr", bus.imemaddr, 32'h20);
    check_eq("redir_hit_pcen", 32'(bus.pc_EN), 32'd1);
    check_eq("redir_hit_pcnext", bus.pc_next, 32'h200);
    tick();
    bus.redirect = 1'b0;
    #1;
    check_eq("redir_hit_valid", 32'(bus.ifid_valid), 32'd0);
    check_eq("redir_hit_newaddr", bus.imemaddr, 32'h200);
    tick();
    check_eq("redir_tgt_valid", 32'(bus.ifid_valid), 32'd1);
    check_eq("redir_tgt_pc", bus.ifid_pc, 32'h200);

    // 4. Redirect while waiting at 0x40.
    bus.ihit = 1'b0;
    set_pc   = 1'b1;
    set_val  = 32'h40;
    tick();
    set_pc          = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h300;
    #1;
    check_eq("redir_wait_pcen", 32'(bus.pc_EN), 32'd1);
    check_eq("redir_wait_pcnext", bus.pc_next, 32'h300);
    tick();
    bus.redirect = 1'b0;
    #1;
    check_eq("drop1_addr", bus.imemaddr, 32'h40);
    check_eq("drop1_ren", 32'(bus.imemREN), 32'd1);
    check_eq("drop1_valid", 32'(bus.ifid_valid), 32'd0);
    tick();
    check_eq("drop2_addr", bus.imemaddr, 32'h40);
    check_eq("drop2_pcen", 32'(bus.pc_EN), 32'd0);
    tick();
    bus.ihit = 1'b1;
    #1;
    check_eq("drop3_addr", bus.imemaddr, 32'h40);
    check_eq("drop3_pcen", 32'(bus.pc_EN), 32'd0);
    tick();
    check_eq("after_drop_addr", bus.imemaddr, 32'h300);
    check_eq("after_drop_valid", 32'(bus.ifid_valid), 32'd0);
    tick();
    check_eq("tgt300_valid", 32'(bus.ifid_valid), 32'd1);
    check_eq("tgt300_pc", bus.ifid_pc, 32'h300);
    check_eq("tgt300_instr", bus.ifid_instr, 32'hA5A5_0300);

    // 5. Halt at 0x50, then reset.
    bus.ihit = 1'b0;
    set_pc   = 1'b1;
    set_val  = 32'h50;
    tick();
    set_pc   = 1'b0;
    bus.halt = 1'b1;
    #1;
    check_eq("halt_addr", bus.imemaddr, 32'h50);
    tick();
    bus.halt = 1'b0;
    bus.ihit = 1'b1;
    #1;
    check_eq("halted_ren", 32'(bus.imemREN), 32'd0);
    check_eq("halted_pcen", 32'(bus.pc_EN), 32'd0);
    check_eq("halted_valid", 32'(bus.ifid_valid), 32'd0);
    tick();
    check_eq("halted2_ren", 32'(bus.imemREN), 32'd0);
    check_eq("halted2_pcen", 32'(bus.pc_EN), 32'd0);
    rst = 1'b1;
    #1;
    check_eq("rst2_ren", 32'(bus.imemREN), 32'd0);
    check_eq("rst2_ifid_pc", bus.ifid_pc, 32'h0);
    tick();
    rst      = 1'b0;
    bus.ihit = 1'b0;
    #1;
    check_eq("rst2_idle_ren", 32'(bus.imemREN), 32'd0);
    tick();
    check_eq("rst2_fetch_ren", 32'(bus.imemREN), 32'd1);
    check_eq("rst2_fetch_addr", bus.imemaddr, 32'h0);

    // 6. Wrap-around at the top of the address space.
    set_pc  = 1'b1;
    set_val = 32'hFFFF_FFFC;
    tick();
    set_pc   = 1'b0;
    bus.ihit = 1'b1;
    #1;
    check_eq("wrap_pcnext", bus.pc_next, 32'h0);
    check_eq("wrap_pcen", 32'(bus.pc_EN), 32'd1);
    tick();
    check_eq("wrap_npc", bus.ifid_npc, 32'h0);
    check_eq("wrap_pc", bus.ifid_pc, 32'hFFFF_FFFC);
    check_eq("wrap_valid", 32'(bus.ifid_valid), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
